// File: rtl/traditional_multiplier8_xor_lock64_if.sv
// traditional_multiplier8_xor_lock64_if: operand, key and product bus for the locked multiplier
interface traditional_multiplier8_xor_lock64_if;
  logic [7:0]  operand1_i;
  logic [7:0]  operand2_i;
  logic [63:0] keyinput;
  logic [15:0] result_o;
  modport master (output operand1_i, output operand2_i, output keyinput, input result_o);
  modport slave (input operand1_i, input operand2_i, input keyinput, output result_o);
endinterface

// File: rtl/traditional_multiplier8_xor_lock64.sv
// traditional_multiplier8_xor_lock64: 8x8 multiplier with one XOR/XNOR key gate per partial product,
// reduced by a carry-save Wallace tree and a ripple-carry adder, registered output
module traditional_multiplier8_xor_lock64_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_co
);
  assign o_s  = i_a ^ i_b ^ i_c;
  assign o_co = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module traditional_multiplier8_xor_lock64_ha (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_co
);
  assign o_s  = i_a ^ i_b;
  assign o_co = i_a & i_b;
endmodule

module traditional_multiplier8_xor_lock64_csa (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic [15:0] i_c,
  output logic [15:0] o_s,
  output logic [15:0] o_c
);
  logic [14:0] w_co;
  for (genvar k = 0; k < 15; k++) begin : g_fa
    traditional_multiplier8_xor_lock64_fa u_fa (
      .i_a(i_a[k]), .i_b(i_b[k]), .i_c(i_c[k]), .o_s(o_s[k]), .o_co(w_co[k])
    );
  end
  // bit 15 carry would land at 2^16 and is dropped by the mod-2^16 product
  assign o_s[15] = i_a[15] ^ i_b[15] ^ i_c[15];
  assign o_c     = {w_co, 1'b0};
endmodule

module traditional_multiplier8_xor_lock64 #(
  parameter logic [63:0] KEY_CORRECT = 64'h192F7F0351667DEC
) (
  input logic clk_i,
  input logic rst_i,
  traditional_multiplier8_xor_lock64_if.slave bus
);
  logic [63:0] w_lp;
  logic [15:0] w_row [8];
  logic [15:0] w_s0, w_c0, w_s1, w_c1, w_s2, w_c2, w_s3, w_c3, w_s4, w_c4, w_s5, w_c5;
  logic [15:0] w_sum;
  logic [14:0] w_rc;
  logic [15:0] r_result;
  for (genvar i = 0; i < 8; i++) begin : g_row
    for (genvar j = 0; j < 8; j++) begin : g_col
      assign w_lp[8*i+j] = (bus.operand1_i[i] & bus.operand2_i[j]) ^ bus.keyinput[8*i+j] ^ KEY_CORRECT[8*i+j];
    end
    assign w_row[i] = {8'b0, w_lp[8*i +: 8]} << i;
  end
  // 8 rows -> 6 -> 4 -> 3 -> 2 vectors
  traditional_multiplier8_xor_lock64_csa u_l1a (.i_a(w_row[0]), .i_b(w_row[1]), .i_c(w_row[2]), .o_s(w_s0), .o_c(w_c0));
  traditional_multiplier8_xor_lock64_csa u_l1b (.i_a(w_row[3]), .i_b(w_row[4]), .i_c(w_row[5]), .o_s(w_s1), .o_c(w_c1));
  traditional_multiplier8_xor_lock64_csa u_l2a (.i_a(w_s0), .i_b(w_c0), .i_c(w_s1), .o_s(w_s2), .o_c(w_c2));
  traditional_multiplier8_xor_lock64_csa u_l2b (.i_a(w_c1), .i_b(w_row[6]), .i_c(w_row[7]), .o_s(w_s3), .o_c(w_c3));
  traditional_multiplier8_xor_lock64_csa u_l3 (.i_a(w_s2), .i_b(w_c2), .i_c(w_s3), .o_s(w_s4), .o_c(w_c4));
  traditional_multiplier8_xor_lock64_csa u_l4 (.i_a(w_s4), .i_b(w_c4), .i_c(w_c3), .o_s(w_s5), .o_c(w_c5));
  for (genvar k = 0; k < 15; k++) begin : g_rca
    if (k == 0) begin : g_ha
      traditional_multiplier8_xor_lock64_ha u_ha (.i_a(w_s5[0]), .i_b(w_c5[0]), .o_s(w_sum[0]), .o_co(w_rc[0]));
    end else begin : g_fa
      traditional_multiplier8_xor_lock64_fa u_fa (
        .i_a(w_s5[k]), .i_b(w_c5[k]), .i_c(w_rc[k-1]), .o_s(w_sum[k]), .o_co(w_rc[k])
      );
    end
  end
  assign w_sum[15] = w_s5[15] ^ w_c5[15] ^ w_rc[14];
  always_ff @(posedge clk_i)
    r_result <= rst_i ? 16'h0000 : w_sum;
  assign bus.result_o = r_result;
endmodule

// File: tb/tb_traditional_multiplier8_xor_lock64.sv
// tb_traditional_multiplier8_xor_lock64: directed and random checks of the key-locked multiplier
module tb_traditional_multiplier8_xor_lock64;
  localparam logic [63:0] KC = 64'h192F7F0351667DEC;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  traditional_multiplier8_xor_lock64_if bus ();
  traditional_multiplier8_xor_lock64 dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic [63:0] k);
    logic [15:0] acc = 16'h0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (a[i] & b[j] ^ k[8*i+j] ^ KC[8*i+j]) acc = acc + (16'h1 << (i + j));
    return acc;
  endfunction

  task automatic drive_step(input logic [7:0] a, input logic [7:0] b, input logic [63:0] k);
    bus.operand1_i = a;
    bus.operand2_i = b;
    bus.keyinput = k;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] exp);
    total++;
    if (bus.result_o !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, bus.result_o, exp);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive_step(8'hFF, 8'hFF, KC);
    check("reset_hold", 16'h0000);
    drive_step(8'h29, 8'h7A, KC);
    check("reset_hold2", 16'h0000);
    rst = 1'b0;
  endtask

  task automatic test_correct_key;
    logic [7:0]  va [7] = '{8'h29, 8'h11, 8'h89, 8'h55, 8'h80, 8'h24, 8'hAB};
    logic [7:0]  vb [7] = '{8'h7A, 8'h11, 8'hFF, 8'hAA, 8'h80, 8'h92, 8'h00};
    logic [15:0] vr [7] = '{16'h138A, 16'h0121, 16'h8877, 16'h3872, 16'h4000, 16'h1488, 16'h0000};
    for (int n = 0; n < 7; n++) begin
      drive_step(va[n], vb[n], KC);
      check($sformatf("correct_%0d", n), vr[n]);
    end
  endtask

  task automatic test_key_flip;
    drive_step(8'h00, 8'h00, 64'h192F7F0351667DE8);
    check("flip2_00x00", 16'h0004);
    drive_step(8'h29, 8'h7A, 64'h192F7F0351667DE8);
    check("flip2_29x7A", 16'h138E);
    drive_step(8'h11, 8'h11, 64'h192F7F0351667DE8);
    check("flip2_11x11", 16'h0125);
    drive_step(8'h00, 8'h00, 64'h392F7F0351667DEC);
    check("flip61_00x00", 16'h1000);
    drive_step(8'h80, 8'h80, 64'h392F7F0351667DEC);
    check("flip61_80x80", 16'h5000);
  endtask

  task automatic test_inverted_key;
    drive_step(8'hFF, 8'hFF, ~KC);
    check("inv_FFxFF", 16'h0000);
    drive_step(8'hFF, 8'hFF, KC);
    check("correct_FFxFF", 16'hFE01);
  endtask

  task automatic test_latency_reset;
    drive_step(8'h29, 8'h7A, KC);
    check("lat_first", 16'h138A);
    bus.operand1_i = 8'h11;
    bus.operand2_i = 8'h11;
    #2;
    check("lat_no_edge", 16'h138A);
    @(posedge clk);
    #1;
    check("lat_one_edge", 16'h0121);
    rst = 1'b1;
    drive_step(8'h89, 8'hFF, KC);
    check("mid_reset", 16'h0000);
    rst = 1'b0;
    drive_step(8'h89, 8'hFF, KC);
    check("after_reset", 16'h8877);
  endtask

  task automatic test_back_to_back;
    drive_step(8'h55, 8'hAA, KC);
    check("b2b_0", 16'h3872);
    drive_step(8'h24, 8'h92, KC);
    check("b2b_1", 16'h1488);
    drive_step(8'h80, 8'h80, KC);
    check("b2b_2", 16'h4000);
  endtask

  task automatic test_random;
    logic [7:0] a, b;
    logic [63:0] k;
    for (int n = 0; n < 10000; n++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      k = (n % 4 == 0) ? KC : {32'($urandom), 32'($urandom)};
      drive_step(a, b, k);
      check($sformatf("rand_%0d_%h_%h_%h", n, a, b, k), ref_mul(a, b, k));
    end
  endtask

  initial begin
    bus.operand1_i = 8'h00;
    bus.operand2_i = 8'h00;
    bus.keyinput = KC;
    test_reset;
    test_correct_key;
    test_key_flip;
    test_inverted_key;
    test_latency_reset;
    test_back_to_back;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
